// File: rtl/hdc_loader_pkg.sv
// hdc_loader_pkg: shared types and helpers for the GSR hypervector memory loader.
// Holds the hypervector width, the loader state and memory-select encodings, and
// the chunk-count helper that the top and the deserializer both size themselves from.
package hdc_loader_pkg;

  // Hypervector width, kept equal to HV_DIMENSION in const.vh.
  localparam int HV_DIMENSION = 2000;

  // Loader control states; RDBK and CHECK are only reachable in readback builds.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    RDBK  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } loader_state_e;

  // Which memory the incoming chunks currently belong to.
  typedef enum logic [1:0] {
    SEL_IM  = 2'd0,
    SEL_POS = 2'd1,
    SEL_NEG = 2'd2
  } mem_sel_e;

  // Number of chunks needed to cover one hypervector (the last may be partial).
  function automatic int calc_chunks(input int hv_width, input int chunk_width);
    return (hv_width + chunk_width - 1) / chunk_width;
  endfunction

endpackage

// File: rtl/hv_deserializer.sv
// hv_deserializer: assembles one hypervector from fixed-width chunks.
// Chunk k lands on bits [k*chunk_width +: chunk_width]; the final chunk is
// truncated at hv_width, so its surplus upper bits never reach the word.
module hv_deserializer
  import hdc_loader_pkg::*;
#(
  parameter int hv_width    = HV_DIMENSION,
  parameter int chunk_width = 64,
  parameter int idx_width   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   insert,
  input  logic [idx_width-1:0]   idx,
  input  logic [chunk_width-1:0] chunk,
  output logic [hv_width-1:0]    word
);

  localparam int NUM_SLICES = calc_chunks(hv_width, chunk_width);

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    localparam int LO = k * chunk_width;
    localparam int W  = ((hv_width - LO) < chunk_width) ? (hv_width - LO) : chunk_width;

    logic [W-1:0] slice_q;

    // Each slice captures its part of the chunk only when the index selects it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slice_q <= '0;
      end else if (clear) begin
        slice_q <= '0;
      end else if (insert && (idx == idx_width'(k))) begin
        slice_q <= chunk[W-1:0];
      end
    end

    assign word[LO +: W] = slice_q;
  end

endmodule

// File: rtl/hv_memory_loader_gsr.sv
// hv_memory_loader_gsr: streaming write-side loader for the GSR IM, PROJM_POS and
// PROJM_NEG hypervector banks. Chunks arrive over valid/ready in the order
// IM, POS, NEG per entry; once all three words of an entry are assembled a single
// active-low strobe writes them at the same address in one cycle.
// Optional feature: define LOADER_READBACK_EN to read each entry back after the
// write and flag any mismatch on the sticky load_error output.
module hv_memory_loader_gsr
  import hdc_loader_pkg::*;
#(
  parameter int sram_addr_width = 5,
  parameter int num_entries     = 32,
  parameter int chunk_width     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [chunk_width-1:0]     din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       we,
  output logic [sram_addr_width-1:0] im_addr,
  output logic [sram_addr_width-1:0] projm_pos_addr,
  output logic [sram_addr_width-1:0] projm_neg_addr,
  output logic [HV_DIMENSION-1:0]    im_din,
  output logic [HV_DIMENSION-1:0]    projm_pos_din,
  output logic [HV_DIMENSION-1:0]    projm_neg_din,
`ifdef LOADER_READBACK_EN
  output logic                       load_error,
  input  logic [HV_DIMENSION-1:0]    im_dout,
  input  logic [HV_DIMENSION-1:0]    projm_pos_dout,
  input  logic [HV_DIMENSION-1:0]    projm_neg_dout,
`endif
  output logic                       load_done
);

  localparam int CHUNKS = calc_chunks(HV_DIMENSION, chunk_width);
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [CNT_W-1:0]           LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [sram_addr_width-1:0] LAST_ENTRY = sram_addr_width'(num_entries - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_RECV  = RECV;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_DONE  = DONE;
`ifdef LOADER_READBACK_EN
  localparam logic [2:0] S_RDBK  = RDBK;
  localparam logic [2:0] S_CHECK = CHECK;
`endif

  logic [2:0]                 state_q;
  logic [2:0]                 state_d;
  logic [CNT_W-1:0]           chunk_cnt_q;
  logic [sram_addr_width-1:0] entry_cnt_q;
  mem_sel_e                   sel_q;

  logic accept;
  logic start_go;
  logic last_chunk;
  logic last_entry;
  logic entry_finish;

  assign accept     = din_valid && din_ready;
  assign start_go   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_chunk = (chunk_cnt_q == LAST_CHUNK);
  assign last_entry = (entry_cnt_q == LAST_ENTRY);

  // An entry is complete after its write, or after its readback check when enabled.
`ifdef LOADER_READBACK_EN
  assign entry_finish = (state_q == S_CHECK);
`else
  assign entry_finish = (state_q == S_WRITE);
`endif

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_RECV;
      end
      S_RECV: begin
        if (accept && last_chunk && (sel_q == SEL_NEG)) state_d = S_WRITE;
      end
`ifdef LOADER_READBACK_EN
      S_WRITE: state_d = S_RDBK;
      S_RDBK:  state_d = S_CHECK;
      S_CHECK: state_d = last_entry ? S_DONE : S_RECV;
`else
      S_WRITE: state_d = last_entry ? S_DONE : S_RECV;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset drops straight back to IDLE so the strobe releases at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Chunk, memory-select and entry counters; a new load starts them all from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_cnt_q <= '0;
      sel_q       <= SEL_IM;
      entry_cnt_q <= '0;
    end else if (start_go) begin
      chunk_cnt_q <= '0;
      sel_q       <= SEL_IM;
      entry_cnt_q <= '0;
    end else begin
      if (accept) begin
        if (last_chunk) begin
          chunk_cnt_q <= '0;
          case (sel_q)
            SEL_IM:  sel_q <= SEL_POS;
            SEL_POS: sel_q <= SEL_NEG;
            default: sel_q <= SEL_IM;
          endcase
        end else begin
          chunk_cnt_q <= chunk_cnt_q + CNT_W'(1);
        end
      end
      if (entry_finish && !last_entry) begin
        entry_cnt_q <= entry_cnt_q + sram_addr_width'(1);
      end
    end
  end

  hv_deserializer #(
    .hv_width    (HV_DIMENSION),
    .chunk_width (chunk_width),
    .idx_width   (CNT_W)
  ) u_im_deser (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_go),
    .insert (accept && (sel_q == SEL_IM)),
    .idx    (chunk_cnt_q),
    .chunk  (din),
    .word   (im_din)
  );

  hv_deserializer #(
    .hv_width    (HV_DIMENSION),
    .chunk_width (chunk_width),
    .idx_width   (CNT_W)
  ) u_pos_deser (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_go),
    .insert (accept && (sel_q == SEL_POS)),
    .idx    (chunk_cnt_q),
    .chunk  (din),
    .word   (projm_pos_din)
  );

  hv_deserializer #(
    .hv_width    (HV_DIMENSION),
    .chunk_width (chunk_width),
    .idx_width   (CNT_W)
  ) u_neg_deser (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_go),
    .insert (accept && (sel_q == SEL_NEG)),
    .idx    (chunk_cnt_q),
    .chunk  (din),
    .word   (projm_neg_din)
  );

`ifdef LOADER_READBACK_EN
  logic readback_mismatch;

  assign readback_mismatch = (im_dout != im_din) ||
                             (projm_pos_dout != projm_pos_din) ||
                             (projm_neg_dout != projm_neg_din);

  // Sticky error: set by any CHECK mismatch, cleared only by reset or a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_error <= 1'b0;
    end else if (start_go) begin
      load_error <= 1'b0;
    end else if ((state_q == S_CHECK) && readback_mismatch) begin
      load_error <= 1'b1;
    end
  end
`endif

  assign din_ready      = (state_q == S_RECV);
  assign we             = (state_q != S_WRITE);
  assign load_done      = (state_q == S_DONE);
  assign im_addr        = entry_cnt_q;
  assign projm_pos_addr = entry_cnt_q;
  assign projm_neg_addr = entry_cnt_q;

endmodule

// File: tb/tb_hv_memory_loader_gsr.sv
// tb_hv_memory_loader_gsr: directed bench for hv_memory_loader_gsr at default
// parameters. A behavioural SRAM captures every write strobe; loaded contents are
// compared against words rebuilt from the chunk pattern. Builds with or without
// LOADER_READBACK_EN (readback build adds a stuck-bit SRAM case).
module tb_hv_memory_loader_gsr;
  import hdc_loader_pkg::*;

  localparam int HV        = 2000;
  localparam int CW        = 64;
  localparam int NCHUNK    = 32;
  localparam int NENT      = 32;
  localparam int PER_HV    = 3 * NCHUNK;
  localparam int TOTAL     = NENT * PER_HV;
`ifdef LOADER_READBACK_EN
  localparam int EXP_DONE  = NENT * (PER_HV + 3);
`else
  localparam int EXP_DONE  = NENT * (PER_HV + 1);
`endif
  localparam int LIMIT     = 12000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          we;
  logic [4:0]    im_addr, projm_pos_addr, projm_neg_addr;
  logic [HV-1:0] im_din, projm_pos_din, projm_neg_din;
  logic          load_done;
`ifdef LOADER_READBACK_EN
  logic          load_error;
  logic [HV-1:0] im_dout = '0, projm_pos_dout = '0, projm_neg_dout = '0;
`endif

  logic [HV-1:0] mem_im  [0:NENT-1];
  logic [HV-1:0] mem_pos [0:NENT-1];
  logic [HV-1:0] mem_neg [0:NENT-1];

  int  vectors     = 0;
  int  miscompares = 0;
  int  write_cnt   = 0;
  bit  prev_we_low = 1'b0;
  bit  stuck_en    = 1'b0;
  int  cyc;

  hv_memory_loader_gsr #(
    .sram_addr_width (5),
    .num_entries     (NENT),
    .chunk_width     (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .din            (din),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .we             (we),
    .im_addr        (im_addr),
    .projm_pos_addr (projm_pos_addr),
    .projm_neg_addr (projm_neg_addr),
    .im_din         (im_din),
    .projm_pos_din  (projm_pos_din),
    .projm_neg_din  (projm_neg_din),
`ifdef LOADER_READBACK_EN
    .load_error     (load_error),
    .im_dout        (im_dout),
    .projm_pos_dout (projm_pos_dout),
    .projm_neg_dout (projm_neg_dout),
`endif
    .load_done      (load_done)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream pattern: tags entry/sel/chunk, bit 0 always set.
  function automatic logic [63:0] chunk_val(input int e, input int s, input int k, input bit a5);
    logic [63:0] c;
    if (a5 && (k == NCHUNK - 1)) begin
      c = {48'hFFFF_FFFF_FFFF, 16'hA5A5};
    end else begin
      c = {8'hC3, 8'(e), 8'(s), 8'(k), 32'h9E37_79B9 ^ {8'(k), 8'(e), 8'(s), 8'(e + k)}};
      c[0] = 1'b1;
    end
    return c;
  endfunction

  // Expected hypervector: chunks placed at k*CW, everything past bit HV-1 dropped.
  function automatic logic [HV-1:0] exp_word(input int e, input int s, input bit a5);
    logic [HV-1:0] w;
    logic [63:0]   c;
    w = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      c = chunk_val(e, s, k, a5);
      for (int b = 0; b < CW; b++) begin
        if (k * CW + b < HV) w[k * CW + b] = c[b];
      end
    end
    return w;
  endfunction

  // Rotate-xor fold of a hypervector, so one report line stays short.
  function automatic logic [63:0] sig(input logic [HV-1:0] w);
    logic [63:0] s, c;
    s = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      c = '0;
      for (int b = 0; b < CW; b++) begin
        if (k * CW + b < HV) c[b] = w[k * CW + b];
      end
      s = {s[62:0], s[63]} ^ c;
    end
    return s;
  endfunction

  // Write-port monitor and SRAM model: records each strobe, checks address order and pulse width.
  always @(negedge clk) begin
    if (we === 1'b0) begin
      checkOutput("we_single_cycle", 64'(prev_we_low), 64'd0);
      checkOutput("im_addr_order",   64'(im_addr),        64'(write_cnt));
      checkOutput("pos_addr_order",  64'(projm_pos_addr), 64'(write_cnt));
      checkOutput("neg_addr_order",  64'(projm_neg_addr), 64'(write_cnt));
`ifdef LOADER_READBACK_EN
      checkOutput("err_at_write", 64'(load_error), 64'(stuck_en && (write_cnt >= 8)));
`endif
      mem_im[im_addr]         = im_din;
      mem_pos[projm_pos_addr] = projm_pos_din;
      mem_neg[projm_neg_addr] = projm_neg_din;
      write_cnt++;
    end
    prev_we_low = (we === 1'b0);
  end

`ifdef LOADER_READBACK_EN
  // Synchronous read port; optional stuck-at-0 on IM entry 7 bit 0.
  always @(posedge clk) begin
    im_dout        <= mem_im[im_addr] & ~((stuck_en && im_addr == 5'd7) ? HV'(1) : HV'(0));
    projm_pos_dout <= mem_pos[projm_pos_addr];
    projm_neg_dout <= mem_neg[projm_neg_addr];
  end
`endif

  task automatic clearModel();
    for (int e = 0; e < NENT; e++) begin
      mem_im[e]  = '0;
      mem_pos[e] = '0;
      mem_neg[e] = '0;
    end
    write_cnt = 0;
  endtask

  task automatic checkMemory(input bit a5);
    for (int e = 0; e < NENT; e++) begin
      checkOutput($sformatf("im[%0d]", e),  sig(mem_im[e]),  sig(exp_word(e, 0, a5)));
      checkOutput($sformatf("pos[%0d]", e), sig(mem_pos[e]), sig(exp_word(e, 1, a5)));
      checkOutput($sformatf("neg[%0d]", e), sig(mem_neg[e]), sig(exp_word(e, 2, a5)));
    end
  endtask

  // Pulses start, streams chunks (optional gaps / busy starts / early abort), waits for load_done.
  task automatic applyStimulus(input bit a5, input int gap_pct, input bit busy_starts,
                               input int abort_at, output int cycles);
    int  idx;
    bit  valid;
    idx = 0;
    @(negedge clk);
    checkOutput("ready_before_start", 64'(din_ready), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    checkOutput("ready_after_start", 64'(din_ready), 64'd1);
    while ((load_done !== 1'b1) && (cycles < LIMIT)) begin
      if ((abort_at >= 0) && (idx == abort_at)) break;
      valid     = (idx < TOTAL) && ((gap_pct == 0) || ($urandom_range(99) >= gap_pct));
      din_valid = valid;
      din       = chunk_val(idx / PER_HV, (idx / NCHUNK) % 3, idx % NCHUNK, a5);
      start     = busy_starts && ((cycles % 400) == 200);
      if (valid && din_ready) idx++;
      @(negedge clk);
      cycles++;
    end
    start     = 1'b0;
    din_valid = 1'b0;
    if (abort_at < 0) begin
      checkOutput("load_done", 64'(load_done), 64'd1);
      checkOutput("chunks_sent", 64'(idx), 64'(TOTAL));
`ifdef LOADER_READBACK_EN
      checkOutput("load_error_end", 64'(load_error), 64'(stuck_en));
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din = '0; din_valid = 1'b0;
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_we",        64'(we),             64'd1);
    checkOutput("rst_din_ready", 64'(din_ready),      64'd0);
    checkOutput("rst_load_done", 64'(load_done),      64'd0);
    checkOutput("rst_im_addr",   64'(im_addr),        64'd0);
    checkOutput("rst_pos_addr",  64'(projm_pos_addr), 64'd0);
    checkOutput("rst_neg_addr",  64'(projm_neg_addr), 64'd0);
    checkOutput("rst_im_din",    sig(im_din),         64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", 64'(din_ready), 64'd0);

    $display("[TB] full-rate load");
    clearModel();
    applyStimulus(1'b0, 0, 1'b0, -1, cyc);
    checkOutput("done_latency", 64'(cyc), 64'(EXP_DONE));
    checkOutput("write_count", 64'(write_cnt), 64'(NENT));
    checkMemory(1'b0);
    repeat (20) @(negedge clk);
    checkOutput("done_hold", 64'(load_done), 64'd1);
    checkOutput("no_extra_writes", 64'(write_cnt), 64'(NENT));

    $display("[TB] gapped load with start pulses while busy");
    clearModel();
    applyStimulus(1'b0, 30, 1'b1, -1, cyc);
    repeat (20) @(negedge clk);
    checkOutput("gap_write_count", 64'(write_cnt), 64'(NENT));
    checkMemory(1'b0);

    $display("[TB] truncated last chunk");
    clearModel();
    applyStimulus(1'b1, 0, 1'b0, -1, cyc);
    checkMemory(1'b1);
    checkOutput("a5_im0",   64'(mem_im[0][HV-1:HV-16]),   64'hA5A5);
    checkOutput("a5_pos31", 64'(mem_pos[31][HV-1:HV-16]), 64'hA5A5);
    checkOutput("a5_neg17", 64'(mem_neg[17][HV-1:HV-16]), 64'hA5A5);

    $display("[TB] reset in the middle of entry 5");
    clearModel();
    applyStimulus(1'b0, 0, 1'b0, 5 * PER_HV + 40, cyc);
    checkOutput("pre_reset_writes", 64'(write_cnt), 64'd5);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we",        64'(we),        64'd1);
    checkOutput("mid_rst_din_ready", 64'(din_ready), 64'd0);
    checkOutput("mid_rst_addr",      64'(im_addr),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", 64'(din_ready), 64'd0);
    clearModel();
    applyStimulus(1'b0, 0, 1'b0, -1, cyc);
    checkOutput("reload_write_count", 64'(write_cnt), 64'(NENT));
    checkMemory(1'b0);

`ifdef LOADER_READBACK_EN
    $display("[TB] readback with stuck IM bit");
    stuck_en = 1'b1;
    clearModel();
    applyStimulus(1'b0, 0, 1'b0, -1, cyc);
    checkOutput("stuck_done_latency", 64'(cyc), 64'(EXP_DONE));
    repeat (5) @(negedge clk);
    checkOutput("stuck_error_sticky", 64'(load_error), 64'd1);
    stuck_en = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hv_memory_loader_gsr.md
# hv_memory_loader_gsr

Streaming write-side loader for the GSR channel's hypervector SRAM banks: the IM, PROJM_POS and PROJM_NEG banks. It accepts hypervector data as narrow chunks over a valid/ready interface and assembles one full `HV_DIMENSION`-bit word for each of the three memories. It then drives a single shared active-low write strobe so that all three banks are written at the same entry address in one cycle. It sits between the off-chip/configuration stream and the GSR memory wrapper, and owns the wrapper's write ports until `load_done`.

## Interface
Parameters:
- `sram_addr_width`, 5: entry address width, matches the memory wrapper.
- `num_entries`, 32: entries loaded per memory, 1..2^`sram_addr_width`.
- `chunk_width`, 64: input stream width. `HV_DIMENSION` (from `const.vh`, 2000) is not required to be a multiple of it.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a load.
- `din`  in  `chunk_width`  chunk data.
- `din_valid`  in  1  chunk valid.
- `din_ready`  out  1  loader accepts a chunk.
- `we`  out  1  active-low write strobe to the wrapper (SRAM WEB).
- `im_addr`, `projm_pos_addr`, `projm_neg_addr`  out  `sram_addr_width`  entry address.
- `im_din`, `projm_pos_din`, `projm_neg_din`  out  `HV_DIMENSION`  write data.
- `load_done`  out  1  all entries written; held high until the next `start`.
- `load_error`  out  1  sticky readback mismatch (`LOADER_READBACK_EN` only).
- `im_dout`, `projm_pos_dout`, `projm_neg_dout`  in  `HV_DIMENSION`  SRAM read data (`LOADER_READBACK_EN` only).

## Operation
- `CHUNKS = ceil(HV_DIMENSION/chunk_width)`, which is 32 at the defaults.
- Chunk k of a hypervector maps to bits [k*chunk_width +: chunk_width], truncated at `HV_DIMENSION`. With the defaults, only the low 16 bits of chunk 31 are used and its upper 48 bits are ignored.
- Stream order per entry: IM hypervector, then PROJM_POS, then PROJM_NEG. Within each hypervector, chunk 0 comes first.
- States:
  - IDLE → RECV on `start`.
  - RECV: a chunk is accepted when `din_valid && din_ready`. After the final chunk of PROJM_NEG, go to WRITE.
  - WRITE: one cycle, `we`=0, all three addresses = `entry_cnt`. Then:
    - without the macro, go to RECV, or to DONE if this was the last entry;
    - with the macro, go to RDBK.
  - DONE: `load_done`=1. A `start` pulse returns to RECV with counters cleared and `load_done` cleared.
- `din_ready` = 1 only in RECV.
- `start` outside IDLE or DONE is ignored.
- Addresses and din outputs are registered and held stable whenever `we`=0. `we` is never low for more than one consecutive cycle.
- Counters:
  - `chunk_cnt` wraps CHUNKS-1 → 0 and advances `sel` (IM → POS → NEG).
  - `entry_cnt` increments after WRITE (or after CHECK with the macro).

## Timing
- Reset values: `we`=1, `din_ready`=0, `load_done`=0, `load_error`=0, all addresses 0, all din outputs 0. All counters clear and the state is IDLE.
- `din_ready` rises the cycle after `start` is sampled.
- At full rate, each entry takes 3*CHUNKS receive cycles + 1 WRITE cycle (+2 with the macro). At the defaults: 97 cycles per entry, 3104 cycles for 32 entries.
- `load_done` rises the cycle after the last WRITE (or the last CHECK with the macro).
- Reset mid-operation: immediate return to IDLE and buffered data is discarded. `we` returns to 1 asynchronously. SRAM contents are partial, and the system must reissue `start`.

## Configuration
- `LOADER_READBACK_EN` defined:
  - Adds states RDBK (`we`=1, same address; SRAM read launched) and CHECK (SRAM Q is valid). In CHECK, each `*_dout` is compared against its buffered word.
  - Any mismatch sets `load_error`, which stays set until reset or `start`. The load still continues.
  - Adds the `*_dout` input ports and the `load_error` output port.
- `LOADER_READBACK_EN` undefined: the `*_dout` and `load_error` ports and the RDBK/CHECK states are absent.

## Structure
- Package `hdc_loader_pkg` contains:
  - the state enum {IDLE, RECV, WRITE, RDBK, CHECK, DONE};
  - the memory-select enum {SEL_IM, SEL_POS, SEL_NEG};
  - the CHUNKS computation function.
- Sub-module `hv_deserializer`: inserts a chunk at a given index into an `HV_DIMENSION` register. It is instantiated three times, or once with a select.

## Test plan
- Reset: hold `rst`=1 → `we`=1, `din_ready`=0, `load_done`=0, all addresses 0.
- Full-rate load of 32 entries, each chunk = {entry, sel, chunk_idx} pattern:
  - exactly 32 single-cycle `we`=0 pulses at addresses 0..31 with matching din words;
  - `load_done` rises 3104 cycles after the first accepted chunk (+1 cycle).
- Random `din_valid` gaps, plus `start` pulses while busy → identical SRAM contents to the full-rate load, and no extra loads are triggered.
- Last chunk of every hypervector has upper 48 bits all 1 and low 16 bits = 0xA5A5 → din[1999:1984] = 0xA5A5, and no other bits are corrupted.
- `rst` asserted after 40 chunks of entry 5 → IDLE next cycle with `we`=1. A subsequent `start` rewrites entries from 0.
- With `LOADER_READBACK_EN`: SRAM model with IM entry 7 bit 0 stuck at 0, stream bit 0 = 1 → `load_error` rises in entry 7's CHECK cycle, stays high, and `load_done` is still reached.
